ex_issue: RTL

EX_ISSUE -- requirements
Module: ex_issue

---
 rtl/ex_issue.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/ex_issue.sv
// ex_issue: single-entry issue register between decode and execute.
// Holds one decoded instruction and drives the ALU directly from registers.
// Operands are forwarded from MEM/WB at capture. While the entry is stalled,
// the stored operands keep tracking later writebacks to the same register.
module ex_issue #(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    // decode-side handshake and decoded fields
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [3:0]    in_op,
    input  logic [4:0]    in_sa,
    input  logic [4:0]    in_rs_idx,
    input  logic [4:0]    in_rt_idx,
    input  logic [4:0]    in_rd_idx,
    input  logic          in_wen,
    input  logic [DW-1:0] in_rs_val,
    input  logic [DW-1:0] in_rt_val,
    // forwarding sources
    input  logic          mem_wen,
    input  logic [4:0]    mem_idx,
    input  logic [DW-1:0] mem_data,
    input  logic          wb_wen,
    input  logic [4:0]    wb_idx,
    input  logic [DW-1:0] wb_data,
    input  logic          flush,
    // execute-side handshake and ALU drive
    output logic          out_valid,
    input  logic          out_ready,
    output logic [3:0]    alu_op,
    output logic [DW-1:0] alu_rs,
    output logic [DW-1:0] alu_rt,
    output logic [4:0]    alu_sa,
    output logic [4:0]    out_rd_idx,
    output logic          out_wen,
    output logic [15:0]   stall_cnt
);

    // Source register indices kept with the entry so a stalled operand can
    // keep matching writebacks.
    logic [4:0]    rs_idx_q;
    logic [4:0]    rt_idx_q;
    logic          capture;
    logic          stalled;
    logic [4:0]    rs_src_idx;
    logic [4:0]    rt_src_idx;
    logic [DW-1:0] rs_base;
    logic [DW-1:0] rt_base;
    logic [DW-1:0] rs_fwd;
    logic [DW-1:0] rt_fwd;

    // Bypass selection: MEM is younger than WB, so it wins; register 0 is
    // hard-wired and never bypassed.
    function automatic logic [DW-1:0] bypass(
        input logic [4:0]    idx,
        input logic [DW-1:0] dflt,
        input logic          m_wen,
        input logic [4:0]    m_idx,
        input logic [DW-1:0] m_data,
        input logic          w_wen,
        input logic [4:0]    w_idx,
        input logic [DW-1:0] w_data
    );
        logic [DW-1:0] r;
        r = dflt;
        if (idx != 5'd0 && m_wen && m_idx == idx)
            r = m_data;
        else if (idx != 5'd0 && w_wen && w_idx == idx)
            r = w_data;
        return r;
    endfunction

    // Handshake: accept whenever the slot is empty or draining this cycle.
    always_comb begin
        in_ready = !out_valid || out_ready;
        capture  = in_valid && in_ready && !flush;
        stalled  = out_valid && !out_ready;
    end

    // Operand source: fresh register-file data at capture, the stored operand
    // while holding.
    always_comb begin
        rs_src_idx = capture ? in_rs_idx : rs_idx_q;
        rt_src_idx = capture ? in_rt_idx : rt_idx_q;
        rs_base    = capture ? in_rs_val : alu_rs;
        rt_base    = capture ? in_rt_val : alu_rt;
        rs_fwd     = bypass(rs_src_idx, rs_base, mem_wen, mem_idx, mem_data,
                            wb_wen, wb_idx, wb_data);
        rt_fwd     = bypass(rt_src_idx, rt_base, mem_wen, mem_idx, mem_data,
                            wb_wen, wb_idx, wb_data);
    end

    // Entry register: flush beats capture, capture beats drain, drain beats hold.
    // Payload fields are kept on flush/drain; only valid/wen are cleared.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: every register here is state, so non-blocking assignments keep
        // each read seeing the pre-edge value regardless of statement order.
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out_wen    <= 1'b0;
            alu_op     <= '0;
            alu_rs     <= '0;
            alu_rt     <= '0;
            alu_sa     <= '0;
            out_rd_idx <= '0;
            rs_idx_q   <= '0;
            rt_idx_q   <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
            out_wen   <= 1'b0;
        end else if (capture) begin
            out_valid  <= 1'b1;
            out_wen    <= in_wen;
            alu_op     <= in_op;
            alu_sa     <= in_sa;
            out_rd_idx <= in_rd_idx;
            rs_idx_q   <= in_rs_idx;
            rt_idx_q   <= in_rt_idx;
            alu_rs     <= rs_fwd;
            alu_rt     <= rt_fwd;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            out_wen   <= 1'b0;
        end else if (out_valid) begin
            alu_rs <= rs_fwd;
            alu_rt <= rt_fwd;
        end
    end

    // Stall counter: counts every edge the entry is blocked, sticks at max.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            stall_cnt <= '0;
        else if (stalled && stall_cnt != 16'hFFFF)
            stall_cnt <= stall_cnt + 16'd1;
    end

endmodule
